// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of an 8:1 bit mux with bounded grants and tagged end-of-grant samples
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   en          scheduler enable
//   req[7:0]    request vector, bit i wants mux input a[i]
//   mux_y       mux output, fed back combinationally from a[sel]
//   sel[2:0]    mux select
//   gnt[7:0]    one-hot grant, zero when idle
//   busy        grant active
//   smp_valid   one-cycle pulse with smp_data (sampled mux_y) and smp_id (owner)
module mux_rr_sched #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       mux_y,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       smp_valid,
  output logic       smp_data,
  output logic [2:0] smp_id
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [3:0] w_idle, w_rel;
  logic       rel;
  // {found, index} of the first set bit of r scanning circularly from p
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] k;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction
  assign w_idle = pick(req, ptr);
  // releasing owner sits last in this scan, so it only wins as sole requester
  assign w_rel  = pick(req, sel + 3'd1);
  assign rel    = !req[sel] || cnt == 4'(HOLD_MAX - 1) || !en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      smp_valid <= 1'b0;
      smp_data  <= 1'b0;
      smp_id    <= '0;
    end else begin
      smp_valid <= 1'b0;
      if (state == IDLE) begin
        if (en && w_idle[3]) begin
          sel   <= w_idle[2:0];
          gnt   <= 8'd1 << w_idle[2:0];
          busy  <= 1'b1;
          cnt   <= '0;
          state <= GRANT;
        end
      end else if (rel) begin
        smp_valid <= 1'b1;
        smp_data  <= mux_y;
        smp_id    <= sel;
        ptr       <= sel + 3'd1;
        if (en && w_rel[3]) begin
          sel <= w_rel[2:0];
          gnt <= 8'd1 << w_rel[2:0];
          cnt <= '0;
        end else begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: two schedulers (HOLD_MAX 4 and 1) against a cycle-level behavioural owner model
module tb_mux_rr_sched;
  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0;
  logic [7:0] req = '0, a = '0;
  logic [2:0] sel0, sel1, id0, id1;
  logic [7:0] gnt0, gnt1;
  logic       busy0, busy1, v0, v1, d0, d1, y0, y1;
  assign y0 = a[sel0];
  assign y1 = a[sel1];
  mux_rr_sched #(.HOLD_MAX(4)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_y(y0),
    .sel(sel0), .gnt(gnt0), .busy(busy0), .smp_valid(v0), .smp_data(d0), .smp_id(id0));
  mux_rr_sched #(.HOLD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_y(y1),
    .sel(sel1), .gnt(gnt1), .busy(busy1), .smp_valid(v1), .smp_data(d1), .smp_id(id1));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int hold [2] = '{4, 1};
  int own [2], len [2], mptr [2], msel [2], mv [2], md [2], mid [2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int find(input int p);
    for (int d = 0; d < 8; d++) if (req[(p + d) % 8]) return (p + d) % 8;
    return -1;
  endfunction
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; len[k] = 0; mptr[k] = 0; msel[k] = 0; mv[k] = 0; md[k] = 0; mid[k] = 0;
    end
  endtask
  task automatic take(input int k);
    own[k] = find(mptr[k]);
    len[k] = 1;
    msel[k] = own[k];
  endtask
  task automatic mstep();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0;
      if (own[k] < 0) begin
        if (en && req != 0) take(k);
      end else if (!req[own[k]] || len[k] == hold[k] || !en) begin
        mv[k] = 1;
        md[k] = int'(a[own[k]]);
        mid[k] = own[k];
        mptr[k] = (own[k] + 1) % 8;
        if (en && req != 0) take(k);
        else own[k] = -1;
      end else begin
        len[k]++;
      end
    end
  endtask
  task automatic cmp1(input int k, input logic [2:0] s, input logic [7:0] g, input logic b,
                      input logic v, input logic d, input logic [2:0] id);
    chk($sformatf("sel%0d", k), 32'(s), 32'(msel[k]));
    chk($sformatf("gnt%0d", k), 32'(g), own[k] < 0 ? 32'd0 : 32'd1 << own[k]);
    chk($sformatf("busy%0d", k), 32'(b), 32'(own[k] >= 0));
    chk($sformatf("smp_valid%0d", k), 32'(v), 32'(mv[k]));
    chk($sformatf("smp_data%0d", k), 32'(d), 32'(md[k]));
    chk($sformatf("smp_id%0d", k), 32'(id), 32'(mid[k]));
  endtask
  task automatic check_all();
    cmp1(0, sel0, gnt0, busy0, v0, d0, id0);
    cmp1(1, sel1, gnt1, busy1, v1, d1, id1);
  endtask
  task automatic step();
    @(posedge clk);
    mstep();
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    check_all();
    #1 rst_n = 1'b1;
  endtask
  initial begin
    mreset();
    #1 do_reset();
    en = 1'b1; req = 8'h08; a = 8'h08;
    repeat (12) step();
    do_reset();
    req = 8'hFF; a = 8'hA5;
    repeat (10) step();
    do_reset();
    req = 8'h20; a = 8'h3C;
    repeat (2) step();
    req = 8'h01;
    repeat (6) step();
    do_reset();
    req = 8'h80; a = 8'h80;
    step();
    req = 8'h81;
    repeat (12) step();
    do_reset();
    req = 8'hFF;
    repeat (2) step();
    en = 1'b0;
    repeat (11) step();
    en = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (3) step();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) req = 8'($urandom);
      en = $urandom_range(0, 7) != 0;
      a = 8'($urandom);
      if ($urandom_range(0, 39) == 0) do_reset();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
